// File: rtl/ft_tx_packetizer.sv
// ft_tx_packetizer: serialises one response packet (status, address, N data
// words) MSB-first onto the FT245 synchronous FIFO byte bus.
// Optional feature macro: FT_TX_SIWU_EN. When it is defined, a one-cycle
// active-low send-immediate pulse follows every packet.
module ft_tx_packetizer #(
    parameter int          DCW         = 28,
    parameter logic [15:0] STALL_LIMIT = 16'hFFFF
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           oh_ready,
    input  logic           oh_en,
    input  logic [31:0]    out_status,
    input  logic [31:0]    out_address,
    input  logic [DCW-1:0] out_data_count,
    input  logic [31:0]    out_data,
    output logic           data_next,
    input  logic           rx_active,
    output logic           tx_active,
    output logic           tx_stall,
    output logic [7:0]     ftdi_data_o,
    output logic           ftdi_data_oe,
    input  logic           ftdi_txe_n,
    output logic           ftdi_wr_n,
    output logic           ftdi_siwu
);

`ifdef FT_TX_SIWU_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, SIWU} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE} state_t;
`endif

    // The stall counter is one bit wider than the limit so "more than
    // STALL_LIMIT cycles" is representable even for the all-ones limit.
    localparam logic [16:0] STALL_SAT = {1'b0, STALL_LIMIT} + 17'd1;

    state_t         state_q, state_d;
    logic [63:0]    shift_q, shift_d;     // remaining bytes of header or current word
    logic [7:0]     byte_q, byte_d;       // byte currently presented on the bus
    logic [2:0]     idx_q, idx_d;         // byte index within header (0..7) or word (0..3)
    logic [DCW-1:0] words_q, words_d;     // data words still to be sent, including current
    logic           wr_n_q, wr_n_d;
    logic           oe_q, oe_d;
    logic           dn_q, dn_d;
    logic           act_q, act_d;
    logic           stall_q, stall_d;
    logic [16:0]    scnt_q, scnt_d;
    logic           siwu_q, siwu_d;
    logic           accept;
    logic           pending;

    assign accept       = ~wr_n_q & ~ftdi_txe_n;
    assign oh_ready     = (state_q == IDLE);
    assign data_next    = dn_q;
    assign tx_active    = act_q;
    assign tx_stall     = stall_q;
    assign ftdi_data_o  = byte_q;
    assign ftdi_data_oe = oe_q;
    assign ftdi_wr_n    = wr_n_q;
    assign ftdi_siwu    = siwu_q;

    // State and datapath registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            words_q <= '0;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            dn_q    <= 1'b0;
            act_q   <= 1'b0;
            stall_q <= 1'b0;
            scnt_q  <= '0;
            siwu_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
            dn_q    <= dn_d;
            act_q   <= act_d;
            stall_q <= stall_d;
            scnt_q  <= scnt_d;
            siwu_q  <= siwu_d;
        end
    end

    // Next-state, byte sequencing, stall tracking and bus strobes.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        words_d = words_q;
        dn_d    = 1'b0;
        stall_d = stall_q;
        scnt_d  = scnt_q;

        // Count consecutive cycles with the FTDI FIFO full while a byte is owed.
        if (state_q == HDR || state_q == DATA) begin
            if (!ftdi_txe_n) begin
                scnt_d = '0;
            end else if (scnt_q != STALL_SAT) begin
                scnt_d = scnt_q + 17'd1;
            end
            if (scnt_d == STALL_SAT) begin
                stall_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (oh_en && !rx_active) begin
                    shift_d = {out_status, out_address};
                    byte_d  = out_status[31:24];
                    idx_d   = '0;
                    words_d = (out_data_count == '0) ? DCW'(1) : out_data_count;
                    stall_d = 1'b0;
                    scnt_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    if (idx_q == 3'd7) begin
                        shift_d = {out_data, 32'h0};
                        byte_d  = out_data[31:24];
                        dn_d    = 1'b1;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        shift_d = shift_q << 8;
                        byte_d  = shift_q[55:48];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (idx_q == 3'd3) begin
                        // words_q is at least 1 here, so the decrement cannot wrap.
                        words_d = words_q - DCW'(1);
                        if (words_q > DCW'(1)) begin
                            shift_d = {out_data, 32'h0};
                            byte_d  = out_data[31:24];
                            dn_d    = 1'b1;
                            idx_d   = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        shift_d = shift_q << 8;
                        byte_d  = shift_q[55:48];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
`ifdef FT_TX_SIWU_EN
            DONE:    state_d = SIWU;
            SIWU:    state_d = IDLE;
`else
            DONE:    state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // wr_n only asserts for a pending byte when the FIFO had room at this edge.
        pending = (state_d == HDR) || (state_d == DATA);
        wr_n_d  = ~pending | ftdi_txe_n;
        oe_d    = pending;
        act_d   = (state_d != IDLE);
`ifdef FT_TX_SIWU_EN
        siwu_d  = (state_d != SIWU);
`else
        siwu_d  = 1'b1;
`endif
    end

endmodule

// File: tb/tb_ft_tx_packetizer.sv
module tb_ft_tx_packetizer;
    localparam int          DCW   = 28;
    localparam logic [15:0] LIMIT = 16'd20;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           oh_ready, oh_en = 1'b0;
    logic [31:0]    out_status = '0, out_address = '0, out_data = '0;
    logic [DCW-1:0] out_data_count = '0;
    logic           data_next, rx_active = 1'b0, tx_active, tx_stall;
    logic [7:0]     ftdi_data_o;
    logic           ftdi_data_oe, ftdi_txe_n = 1'b1, ftdi_wr_n, ftdi_siwu;

    ft_tx_packetizer #(.DCW(DCW), .STALL_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .oh_ready(oh_ready), .oh_en(oh_en),
        .out_status(out_status), .out_address(out_address),
        .out_data_count(out_data_count), .out_data(out_data),
        .data_next(data_next), .rx_active(rx_active), .tx_active(tx_active),
        .tx_stall(tx_stall), .ftdi_data_o(ftdi_data_o), .ftdi_data_oe(ftdi_data_oe),
        .ftdi_txe_n(ftdi_txe_n), .ftdi_wr_n(ftdi_wr_n), .ftdi_siwu(ftdi_siwu)
    );

    always #5 clk = ~clk;

`ifdef FT_TX_SIWU_EN
    localparam int EXP_SIWU = 1;
`else
    localparam int EXP_SIWU = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] words[$];
    logic [7:0]  got[$];
    logic [7:0]  expq[$];
    int dn_cnt, acc_first, acc_last, siwu_cnt, viol, stall_start;
    bit timed_out;

    // Reference packet: status, address, then max(count,1) words, all MSB first.
    function automatic void build_exp(input logic [31:0] st, input logic [31:0] ad, input int cnt);
        int n;
        logic [31:0] w;
        n = (cnt == 0) ? 1 : cnt;
        expq.delete();
        for (int b = 3; b >= 0; b--) expq.push_back(st[b*8 +: 8]);
        for (int b = 3; b >= 0; b--) expq.push_back(ad[b*8 +: 8]);
        for (int k = 0; k < n; k++) begin
            w = words[k];
            for (int b = 3; b >= 0; b--) expq.push_back(w[b*8 +: 8]);
        end
    endfunction

    // Drives one packet with an upstream word source and a txe_n pattern, logging
    // every byte the FTDI side would accept.
    task automatic run_pkt(input logic [31:0] st, input logic [31:0] ad, input int cnt,
                           input int hold_at, input int hold_len, input int txe_pct, input bit junk);
        int wi, cyc, held;
        bit txe, prev_txe;
        got.delete();
        dn_cnt = 0; acc_first = -1; acc_last = -1; siwu_cnt = 0; viol = 0;
        timed_out = 1'b0; held = 0; wi = 0;
        @(negedge clk);
        out_status = st; out_address = ad; out_data_count = DCW'(cnt);
        out_data = words[0]; ftdi_txe_n = 1'b0; oh_en = 1'b1;
        @(negedge clk);
        oh_en = 1'b0; prev_txe = 1'b0; stall_start = tx_stall;
        cyc = 0;
        forever begin
            if (data_next) begin
                dn_cnt++; wi++;
                out_data = (wi < words.size()) ? words[wi] : 32'hDEADBEEF;
            end
            if (!ftdi_siwu) siwu_cnt++;
            if (!tx_active) break;
            if (oh_ready) viol++;
            if (!ftdi_wr_n && (prev_txe || !ftdi_data_oe)) viol++;
            if (hold_at >= 0 && got.size() == hold_at && held < hold_len) begin
                txe = 1'b1; held++;
            end else begin
                txe = ($urandom_range(99) < txe_pct);
            end
            ftdi_txe_n = txe;
            if (junk && cyc == 3) begin
                oh_en = 1'b1; out_status = ~st; out_address = ~ad; out_data_count = DCW'(7);
            end else begin
                oh_en = 1'b0;
            end
            if (!ftdi_wr_n && !txe) begin
                got.push_back(ftdi_data_o);
                if (acc_first < 0) acc_first = cyc;
                acc_last = cyc;
            end
            prev_txe = txe;
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin timed_out = 1'b1; break; end
        end
        ftdi_txe_n = 1'b0;
        build_exp(st, ad, cnt);
    endtask

    // Compares a finished packet against the reference model.
    task automatic check_pkt(input string name, input bit want_no_bubble);
        int n, bad;
        n_checks++;
        if (timed_out !== 1'b0) begin n_fail++; $display("FAIL %s timeout: packet never ended", name); end
        n_checks++;
        if (got.size() !== expq.size()) begin
            n_fail++; $display("FAIL %s length: got %0d bytes, want %0d", name, got.size(), expq.size());
        end
        bad = -1;
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (bad < 0 && got[i] !== expq[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL %s byte[%0d]: got %02h, want %02h", name, bad, got[bad], expq[bad]);
        end
        n = (expq.size() - 8) / 4;
        n_checks++;
        if (dn_cnt !== n) begin n_fail++; $display("FAIL %s data_next: got %0d pulses, want %0d", name, dn_cnt, n); end
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL %s strobe_rule: got %0d violations, want 0", name, viol); end
        n_checks++;
        if (siwu_cnt !== EXP_SIWU) begin n_fail++; $display("FAIL %s siwu: got %0d pulses, want %0d", name, siwu_cnt, EXP_SIWU); end
        n_checks++;
        if ({oh_ready, ftdi_wr_n, ftdi_data_oe} !== 3'b110) begin
            n_fail++; $display("FAIL %s idle_after: got ready/wr_n/oe=%b, want 110", name, {oh_ready, ftdi_wr_n, ftdi_data_oe});
        end
        if (want_no_bubble) begin
            n_checks++;
            if (acc_last - acc_first + 1 !== expq.size()) begin
                n_fail++; $display("FAIL %s bubble: span %0d cycles, want %0d", name, acc_last - acc_first + 1, expq.size());
            end
        end
        $display("packet %s: %0d bytes, %0d data_next, %0d siwu", name, got.size(), dn_cnt, siwu_cnt);
    endtask

    task automatic check_reset_vals(input string name);
        n_checks++;
        if ({oh_ready, ftdi_wr_n, ftdi_siwu, ftdi_data_oe, ftdi_data_o, tx_active, tx_stall, data_next} !== {3'b111, 1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL %s: got rdy/wr_n/siwu/oe/data/act/stall/dn=%b%b%b%b %02h %b%b%b, want 1110 00 000", name,
                     oh_ready, ftdi_wr_n, ftdi_siwu, ftdi_data_oe, ftdi_data_o, tx_active, tx_stall, data_next);
        end
        $display("reset check %s done", name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        words = '{32'h01234567};
        run_pkt(32'hCD000001, 32'h00000100, 1, -1, 0, 0, 1'b0);
        check_pkt("single_word", 1'b1);
    endtask

    task automatic test_count_zero();
        words = '{32'h01234567};
        run_pkt(32'hCD000001, 32'h00000100, 0, -1, 0, 0, 1'b0);
        check_pkt("count_zero", 1'b1);
    endtask

    task automatic test_back_to_back();
        words = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
        run_pkt(32'h11223344, 32'h55667788, 3, -1, 0, 0, 1'b0);
        check_pkt("back_to_back", 1'b1);
    endtask

    task automatic test_txe_hold();
        words = '{32'h01234567};
        run_pkt(32'hCD000001, 32'h00000100, 1, 6, 5, 0, 1'b0);
        check_pkt("txe_hold", 1'b0);
    endtask

    task automatic test_ignore();
        @(negedge clk);
        rx_active = 1'b1; oh_en = 1'b1; out_status = 32'hFFFF0000;
        @(negedge clk);
        oh_en = 1'b0;
        @(negedge clk);
        rx_active = 1'b0;
        n_checks++;
        if ({oh_ready, tx_active, ftdi_data_oe} !== 3'b100) begin
            n_fail++; $display("FAIL rx_block: got ready/act/oe=%b, want 100", {oh_ready, tx_active, ftdi_data_oe});
        end
        $display("rx_active strobe: ready=%b active=%b", oh_ready, tx_active);
        words = '{32'h89ABCDEF, 32'h76543210};
        run_pkt(32'h0BADF00D, 32'hCAFE0004, 2, -1, 0, 0, 1'b1);
        check_pkt("busy_strobe", 1'b1);
    endtask

    task automatic test_stall();
        words = '{32'h13579BDF};
        run_pkt(32'h00000001, 32'h00000002, 1, 2, int'(LIMIT), 0, 1'b0);
        n_checks++;
        if (tx_stall !== 1'b0) begin n_fail++; $display("FAIL stall_at_limit: got %b, want 0", tx_stall); end
        $display("stall hold %0d: tx_stall=%b", int'(LIMIT), tx_stall);
        run_pkt(32'h00000003, 32'h00000004, 1, 2, int'(LIMIT) + 1, 0, 1'b0);
        check_pkt("stall_long", 1'b0);
        n_checks++;
        if (tx_stall !== 1'b1) begin n_fail++; $display("FAIL stall_over_limit: got %b, want 1", tx_stall); end
        $display("stall hold %0d: tx_stall=%b", int'(LIMIT) + 1, tx_stall);
        run_pkt(32'h00000005, 32'h00000006, 1, -1, 0, 0, 1'b0);
        n_checks++;
        if (stall_start !== 0) begin n_fail++; $display("FAIL stall_clear: got %0d, want 0", stall_start); end
        $display("stall after new accept: %0d", stall_start);
    endtask

    task automatic test_reset_mid();
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        @(negedge clk);
        out_status = 32'hAAAA5555; out_address = 32'h5555AAAA; out_data_count = DCW'(4);
        out_data = words[0]; ftdi_txe_n = 1'b0; oh_en = 1'b1;
        @(negedge clk);
        oh_en = 1'b0;
        repeat (11) @(negedge clk);
        n_checks++;
        if ({tx_active, ftdi_wr_n, ftdi_data_oe} !== 3'b101) begin
            n_fail++; $display("FAIL pre_reset_busy: got act/wr_n/oe=%b, want 101", {tx_active, ftdi_wr_n, ftdi_data_oe});
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_data");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        words = '{32'h01234567};
        run_pkt(32'hCD000001, 32'h00000100, 1, -1, 0, 0, 1'b0);
        check_pkt("after_reset", 1'b1);
    endtask

    task automatic test_random();
        int cnt;
        for (int p = 0; p < 6; p++) begin
            cnt = $urandom_range(5);
            words.delete();
            for (int k = 0; k < ((cnt == 0) ? 1 : cnt); k++) words.push_back($urandom);
            run_pkt($urandom, $urandom, cnt, -1, 0, 30, 1'b0);
            check_pkt($sformatf("random%0d_n%0d", p, cnt), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_count_zero();
        test_back_to_back();
        test_txe_hold();
        test_ignore();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
